// File: rtl/gather_pingpong.sv
// Serial-to-parallel channel gather into two ping-pong register banks (fill one, drain the other).
// Optional macro GATHER_LAST_EN adds in_last_i so a vector can be closed before nch_lat words.
module gather_pingpong #(
  parameter  int DW      = 8,
  parameter  int NCH_MAX = 128,
  localparam int CW      = $clog2(NCH_MAX + 1)
) (
  input  logic          clk_tl,
  input  logic          rstn_tl,
  input  logic [CW-1:0] cfg_nch_i,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
`ifdef GATHER_LAST_EN
  input  logic          in_last_i,
`endif
  output logic [DW-1:0] out_data_o [NCH_MAX],
  output logic [CW-1:0] out_len_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [15:0]   vec_cnt_o
);

  localparam int            IW        = $clog2(NCH_MAX);
  localparam logic [CW-1:0] NCH_MAX_C = CW'(NCH_MAX);

  logic [DW-1:0] r_bank [2][NCH_MAX];
  logic [1:0]    r_full;
  logic [CW-1:0] r_len [2];
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [IW-1:0] r_cnt;
  logic [CW-1:0] r_nch_lat;
  logic [15:0]   r_vec_cnt;

  logic [CW-1:0] w_nch_clamp;
  logic [CW-1:0] w_nch_eff;
  logic          w_accept;
  logic          w_last;
  logic          w_close;
  logic          w_drain;

`ifdef GATHER_LAST_EN
  assign w_last = in_last_i;
`else
  assign w_last = 1'b0;
`endif

  // Word 0 closes against the freshly clamped config, later words against the latched one.
  assign w_nch_clamp = ((cfg_nch_i == '0) || (cfg_nch_i > NCH_MAX_C)) ? NCH_MAX_C : cfg_nch_i;
  assign w_nch_eff   = (r_cnt == '0) ? w_nch_clamp : r_nch_lat;

  assign in_ready_o = ~r_full[r_wr_bank];
  assign w_accept   = in_valid_i & in_ready_o;
  assign w_close    = w_accept & ((CW'(r_cnt) == (w_nch_eff - CW'(1))) | w_last);
  assign w_drain    = r_full[r_rd_bank] & out_ready_i;

  always_ff @(posedge clk_tl or negedge rstn_tl) begin
    if (!rstn_tl) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < NCH_MAX; c++) begin
          r_bank[b][c] <= '0;
        end
      end
    end else if (w_accept) begin
      r_bank[r_wr_bank][r_cnt] <= in_data_i;
    end
  end

  always_ff @(posedge clk_tl or negedge rstn_tl) begin
    if (!rstn_tl) begin
      r_full    <= '0;
      r_len[0]  <= '0;
      r_len[1]  <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_cnt     <= '0;
      r_nch_lat <= NCH_MAX_C;
      r_vec_cnt <= '0;
    end else begin
      if (w_accept) begin
        if (r_cnt == '0) begin
          r_nch_lat <= w_nch_clamp;
        end
        if (w_close) begin
          r_cnt     <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_cnt <= r_cnt + IW'(1);
        end
      end
      if (w_close) begin
        r_len[r_wr_bank] <= CW'(r_cnt) + CW'(1);
      end
      if (w_drain) begin
        r_rd_bank <= ~r_rd_bank;
        r_vec_cnt <= r_vec_cnt + 16'd1;
      end
      // A bank closing and the other draining in one cycle never touch the same full bit.
      for (int b = 0; b < 2; b++) begin
        if (w_close && (r_wr_bank == 1'(b))) begin
          r_full[b] <= 1'b1;
        end else if (w_drain && (r_rd_bank == 1'(b))) begin
          r_full[b] <= 1'b0;
        end
      end
    end
  end

  assign out_valid_o = r_full[r_rd_bank];
  assign out_len_o   = r_len[r_rd_bank];
  assign vec_cnt_o   = r_vec_cnt;

  // Channels at or beyond len are forced to zero so a shorter vector never shows stale data.
  for (genvar gi = 0; gi < NCH_MAX; gi++) begin : g_out
    assign out_data_o[gi] = (CW'(gi) < r_len[r_rd_bank]) ? r_bank[r_rd_bank][gi] : '0;
  end

endmodule
